// File: rtl/sysarr_mac_pe.sv
// Weight-stationary systolic-array MAC processing element: double-buffered weight,
// registered east pass-through, valid-tracked multiply/add pipeline with optional saturation.
module sysarr_mac_pe #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int MUL_LEN   = 2,
    parameter int ADD_LEN   = 3,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 en,
    input  logic                 weight_load,
    input  logic [IN_WIDTH-1:0]  weight_in,
    output logic [IN_WIDTH-1:0]  weight_out,
    input  logic                 weight_swap,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_value,
    input  logic [ACC_WIDTH-1:0] in_accumulate,
    output logic [IN_WIDTH-1:0]  in_pass,
    output logic                 pass_valid,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_accumulate
);

    localparam int   PW  = 2 * IN_WIDTH;
    localparam logic SGN = (SIGNED != 0);
    localparam logic SAT = (SATURATE != 0);

    logic [IN_WIDTH-1:0]  shadow_q, active_q, pass_q;
    logic                 pass_v_q;
    logic                 iss_v_q;
    logic [IN_WIDTH-1:0]  iss_a_q, iss_w_q;
    logic [ACC_WIDTH-1:0] iss_acc_q;

    logic [PW-1:0]        a_ext, w_ext, prod_d;
    logic [ACC_WIDTH:0]   p_wide, acc_wide, sum_wide;
    logic [ACC_WIDTH-1:0] sum_d;

    // Weights, east pass path and issue capture.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pass_q    <= '0;
            pass_v_q  <= 1'b0;
            iss_v_q   <= 1'b0;
            iss_a_q   <= '0;
            iss_w_q   <= '0;
            iss_acc_q <= '0;
        end else if (en) begin
            if (weight_load) shadow_q <= weight_in;
            if (weight_swap) active_q <= shadow_q;
            pass_v_q <= in_valid;
            if (in_valid) pass_q <= in_value;
            iss_v_q <= in_valid;
            if (in_valid) begin
                iss_a_q   <= in_value;
                iss_w_q   <= active_q;
                iss_acc_q <= in_accumulate;
            end
        end
    end

    always_comb begin
        a_ext  = {{IN_WIDTH{SGN & iss_a_q[IN_WIDTH-1]}}, iss_a_q};
        w_ext  = {{IN_WIDTH{SGN & iss_w_q[IN_WIDTH-1]}}, iss_w_q};
        prod_d = a_ext * w_ext;
    end

    for (genvar s = 0; s < MUL_LEN; s++) begin : g_mul
        logic                 v_q, v_d;
        logic [PW-1:0]        p_q, p_d;
        logic [ACC_WIDTH-1:0] acc_q, acc_d;

        if (s == 0) begin : g_src
            assign v_d   = iss_v_q;
            assign p_d   = prod_d;
            assign acc_d = iss_acc_q;
        end else begin : g_src
            assign v_d   = g_mul[s-1].v_q;
            assign p_d   = g_mul[s-1].p_q;
            assign acc_d = g_mul[s-1].acc_q;
        end

        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                v_q   <= 1'b0;
                p_q   <= '0;
                acc_q <= '0;
            end else if (en) begin
                v_q   <= v_d;
                p_q   <= p_d;
                acc_q <= acc_d;
            end
        end
    end

    always_comb begin
        p_wide   = {{(ACC_WIDTH + 1 - PW){SGN & g_mul[MUL_LEN-1].p_q[PW-1]}}, g_mul[MUL_LEN-1].p_q};
        acc_wide = {SGN & g_mul[MUL_LEN-1].acc_q[ACC_WIDTH-1], g_mul[MUL_LEN-1].acc_q};
        sum_wide = p_wide + acc_wide;
        sum_d    = sum_wide[ACC_WIDTH-1:0];
        // Signed overflow shows as disagreement of the two top bits; unsigned as a carry.
        if (SAT) begin
            if (SGN) begin
                if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
                    sum_d = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else if (sum_wide[ACC_WIDTH]) begin
                sum_d = '1;
            end
        end
        // Bubbles carry zero data so the output bus is never stale.
        if (!g_mul[MUL_LEN-1].v_q) sum_d = '0;
    end

    for (genvar s = 0; s < ADD_LEN; s++) begin : g_add
        logic                 v_q, v_d;
        logic [ACC_WIDTH-1:0] s_q, s_d;

        if (s == 0) begin : g_src
            assign v_d = g_mul[MUL_LEN-1].v_q;
            assign s_d = sum_d;
        end else begin : g_src
            assign v_d = g_add[s-1].v_q;
            assign s_d = g_add[s-1].s_q;
        end

        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                v_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_d;
                s_q <= s_d;
            end
        end
    end

    assign weight_out     = shadow_q;
    assign in_pass        = pass_q;
    assign pass_valid     = pass_v_q;
    assign out_valid      = g_add[ADD_LEN-1].v_q;
    assign out_accumulate = g_add[ADD_LEN-1].s_q;

endmodule

// File: tb/tb_sysarr_mac_pe.sv
// Directed bench for sysarr_mac_pe: signed-wrap, unsigned-wrap and signed-saturate
// instances driven by a shared stimulus, checked cycle by cycle.
module tb_sysarr_mac_pe;

    logic        clk = 1'b0;
    logic        nRST;
    logic        en;
    logic        weight_load;
    logic [15:0] weight_in;
    logic        weight_swap;
    logic        in_valid;
    logic [15:0] in_value;
    logic [31:0] in_accumulate;

    logic [15:0] wo0, wo_u, wo_s, ip0, ip_u, ip_s;
    logic        pv0, pv_u, pv_s, ov0, ov_u, ov_s;
    logic [31:0] oa0, oa_u, oa_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sysarr_mac_pe #(.IN_WIDTH(16), .ACC_WIDTH(32), .MUL_LEN(2), .ADD_LEN(3), .SIGNED(1), .SATURATE(0)) u_dut (
        .clk(clk), .nRST(nRST), .en(en), .weight_load(weight_load), .weight_in(weight_in),
        .weight_out(wo0), .weight_swap(weight_swap), .in_valid(in_valid), .in_value(in_value),
        .in_accumulate(in_accumulate), .in_pass(ip0), .pass_valid(pv0), .out_valid(ov0),
        .out_accumulate(oa0));

    sysarr_mac_pe #(.IN_WIDTH(16), .ACC_WIDTH(32), .MUL_LEN(2), .ADD_LEN(3), .SIGNED(0), .SATURATE(0)) u_dut_u (
        .clk(clk), .nRST(nRST), .en(en), .weight_load(weight_load), .weight_in(weight_in),
        .weight_out(wo_u), .weight_swap(weight_swap), .in_valid(in_valid), .in_value(in_value),
        .in_accumulate(in_accumulate), .in_pass(ip_u), .pass_valid(pv_u), .out_valid(ov_u),
        .out_accumulate(oa_u));

    sysarr_mac_pe #(.IN_WIDTH(16), .ACC_WIDTH(32), .MUL_LEN(2), .ADD_LEN(3), .SIGNED(1), .SATURATE(1)) u_dut_s (
        .clk(clk), .nRST(nRST), .en(en), .weight_load(weight_load), .weight_in(weight_in),
        .weight_out(wo_s), .weight_swap(weight_swap), .in_valid(in_valid), .in_value(in_value),
        .in_accumulate(in_accumulate), .in_pass(ip_s), .pass_valid(pv_s), .out_valid(ov_s),
        .out_accumulate(oa_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance one edge, then check the signed-wrap output.
    task automatic cyc(input string tag, input logic e, input logic iv, input logic [15:0] v,
                       input logic [31:0] a, input logic wl, input logic [15:0] wi,
                       input logic ws, input logic ev, input logic [31:0] ed);
        en = e; in_valid = iv; in_value = v; in_accumulate = a;
        weight_load = wl; weight_in = wi; weight_swap = ws;
        @(posedge clk); #1;
        chk({tag, "_v"}, {31'b0, ov0}, {31'b0, ev});
        chk({tag, "_d"}, oa0, ed);
    endtask

    task automatic idle(input string tag, input logic ev, input logic [31:0] ed);
        cyc(tag, 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0, ev, ed);
    endtask

    task automatic issue(input string tag, input logic [15:0] v, input logic [31:0] a);
        cyc(tag, 1'b1, 1'b1, v, a, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic load_swap(input string tag, input logic [15:0] w);
        cyc({tag, "_ld"}, 1'b1, 1'b0, 16'h0, 32'h0, 1'b1, w, 1'b0, 1'b0, 32'h0);
        cyc({tag, "_sw"}, 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        nRST = 1'b0; en = 1'b1; weight_load = 1'b0; weight_in = '0; weight_swap = 1'b0;
        in_valid = 1'b0; in_value = '0; in_accumulate = '0;

        // Reset state on all instances.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ov0", {31'b0, ov0}, 32'h0);
        chk("rst_oa0", oa0, 32'h0);
        chk("rst_pv0", {31'b0, pv0}, 32'h0);
        chk("rst_ip0", {16'h0, ip0}, 32'h0);
        chk("rst_wo0", {16'h0, wo0}, 32'h0);
        chk("rst_ovu", {31'b0, ov_u}, 32'h0);
        chk("rst_oau", oa_u, 32'h0);
        chk("rst_pvu", {31'b0, pv_u}, 32'h0);
        chk("rst_ipu", {16'h0, ip_u}, 32'h0);
        chk("rst_wou", {16'h0, wo_u}, 32'h0);
        chk("rst_ovs", {31'b0, ov_s}, 32'h0);
        chk("rst_oas", oa_s, 32'h0);
        chk("rst_pvs", {31'b0, pv_s}, 32'h0);
        chk("rst_ips", {16'h0, ip_s}, 32'h0);
        chk("rst_wos", {16'h0, wo_s}, 32'h0);
        nRST = 1'b1;

        // Single op: 5*3+10 = 25 after five edges.
        cyc("t1_ld", 1'b1, 1'b0, 16'h0, 32'h0, 1'b1, 16'd3, 1'b0, 1'b0, 32'h0);
        chk("t1_wout", {16'h0, wo0}, 32'd3);
        cyc("t1_sw", 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
        issue("t1_iss", 16'd5, 32'd10);
        chk("t1_pass", {16'h0, ip0}, 32'd5);
        chk("t1_pv", {31'b0, pv0}, 32'd1);
        idle("t1_c1", 1'b0, 32'h0);
        chk("t1_pv_lo", {31'b0, pv0}, 32'd0);
        chk("t1_pass_hold", {16'h0, ip0}, 32'd5);
        idle("t1_c2", 1'b0, 32'h0);
        idle("t1_c3", 1'b0, 32'h0);
        idle("t1_c4", 1'b0, 32'h0);
        idle("t1_c5", 1'b1, 32'd25);
        idle("t1_c6", 1'b0, 32'h0);

        // Stream with a bubble, weight 2.
        load_swap("t2", 16'd2);
        issue("t2_i1", 16'd1, 32'd0);
        issue("t2_i2", 16'd2, 32'd0);
        idle("t2_bub", 1'b0, 32'h0);
        issue("t2_i3", 16'd3, 32'd0);
        issue("t2_i4", 16'd4, 32'd0);
        idle("t2_o1", 1'b1, 32'd2);
        idle("t2_o2", 1'b1, 32'd4);
        idle("t2_ob", 1'b0, 32'h0);
        idle("t2_o3", 1'b1, 32'd6);
        idle("t2_o4", 1'b1, 32'd8);
        idle("t2_end", 1'b0, 32'h0);

        // Load/swap/issue interactions.
        load_swap("t3", 16'd3);
        cyc("t3_e0", 1'b1, 1'b1, 16'd1, 32'd0, 1'b1, 16'd7, 1'b1, 1'b0, 32'h0);
        chk("t3_wout7", {16'h0, wo0}, 32'd7);
        issue("t3_e1", 16'd1, 32'd0);
        cyc("t3_e2", 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
        issue("t3_e3", 16'd1, 32'd0);
        cyc("t3_e4", 1'b1, 1'b0, 16'h0, 32'h0, 1'b1, 16'd9, 1'b0, 1'b0, 32'h0);
        chk("t3_wout9", {16'h0, wo0}, 32'd9);
        cyc("t3_e5", 1'b1, 1'b1, 16'd1, 32'd0, 1'b0, 16'h0, 1'b1, 1'b1, 32'd3);
        cyc("t3_e6", 1'b1, 1'b1, 16'd1, 32'd0, 1'b0, 16'h0, 1'b0, 1'b1, 32'd3);
        idle("t3_e7", 1'b0, 32'h0);
        idle("t3_e8", 1'b1, 32'd7);
        idle("t3_e9", 1'b0, 32'h0);
        idle("t3_e10", 1'b1, 32'd7);
        idle("t3_e11", 1'b1, 32'd9);
        idle("t3_e12", 1'b0, 32'h0);

        // Signed vs unsigned operands, weight 3.
        load_swap("t4", 16'd3);
        issue("t4_i1", 16'hFFFE, 32'hFFFF_FFFC);
        issue("t4_i2", 16'hFFFE, 32'h0);
        idle("t4_c2", 1'b0, 32'h0);
        idle("t4_c3", 1'b0, 32'h0);
        idle("t4_c4", 1'b0, 32'h0);
        idle("t4_o1", 1'b1, 32'hFFFF_FFF6);
        chk("t4_u1_v", {31'b0, ov_u}, 32'd1);
        chk("t4_u1_d", oa_u, 32'h0002_FFF6);
        chk("t4_s1_d", oa_s, 32'hFFFF_FFF6);
        idle("t4_o2", 1'b1, 32'hFFFF_FFFA);
        chk("t4_u2_d", oa_u, 32'h0002_FFFA);
        idle("t4_end", 1'b0, 32'h0);
        chk("t4_u_end", oa_u, 32'h0);

        // Overflow: wrap on the default instance, clamp on the saturating one.
        load_swap("t5", 16'd1);
        issue("t5_i1", 16'h00FF, 32'h7FFF_FFF0);
        issue("t5_i2", 16'hFFFF, 32'h8000_0000);
        idle("t5_c2", 1'b0, 32'h0);
        idle("t5_c3", 1'b0, 32'h0);
        idle("t5_c4", 1'b0, 32'h0);
        idle("t5_o1", 1'b1, 32'h8000_00EF);
        chk("t5_sat_max", oa_s, 32'h7FFF_FFFF);
        chk("t5_sat_v", {31'b0, ov_s}, 32'd1);
        idle("t5_o2", 1'b1, 32'h7FFF_FFFF);
        chk("t5_sat_min", oa_s, 32'h8000_0000);
        idle("t5_end", 1'b0, 32'h0);

        // Global stall: three frozen cycles delay results by three, then a stall with output valid.
        issue("t6_i1", 16'd10, 32'd0);
        issue("t6_i2", 16'd20, 32'd0);
        cyc("t6_d1", 1'b0, 1'b1, 16'd99, 32'd5, 1'b1, 16'd55, 1'b1, 1'b0, 32'h0);
        cyc("t6_d2", 1'b0, 1'b1, 16'd99, 32'd5, 1'b1, 16'd55, 1'b1, 1'b0, 32'h0);
        cyc("t6_d3", 1'b0, 1'b1, 16'd99, 32'd5, 1'b1, 16'd55, 1'b1, 1'b0, 32'h0);
        chk("t6_pass_hold", {16'h0, ip0}, 32'd20);
        chk("t6_pv_hold", {31'b0, pv0}, 32'd1);
        chk("t6_wout_hold", {16'h0, wo0}, 32'd1);
        idle("t6_c2", 1'b0, 32'h0);
        idle("t6_c3", 1'b0, 32'h0);
        idle("t6_c4", 1'b0, 32'h0);
        idle("t6_o1", 1'b1, 32'd10);
        cyc("t6_d4", 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1, 32'd10);
        idle("t6_o2", 1'b1, 32'd20);
        idle("t6_end", 1'b0, 32'h0);

        // Asynchronous reset with results in flight.
        issue("t7_i1", 16'd1, 32'd0);
        issue("t7_i2", 16'd2, 32'd0);
        issue("t7_i3", 16'd3, 32'd0);
        issue("t7_i4", 16'd4, 32'd0);
        issue("t7_i5", 16'd5, 32'd0);
        idle("t7_o1", 1'b1, 32'd1);
        nRST = 1'b0;
        #1;
        chk("t7_rst_ov", {31'b0, ov0}, 32'd0);
        chk("t7_rst_oa", oa0, 32'd0);
        chk("t7_rst_ip", {16'h0, ip0}, 32'd0);
        chk("t7_rst_wo", {16'h0, wo0}, 32'd0);
        idle("t7_hold1", 1'b0, 32'h0);
        idle("t7_hold2", 1'b0, 32'h0);
        nRST = 1'b1;
        for (int k = 0; k < 8; k++) idle($sformatf("t7_quiet%0d", k), 1'b0, 32'h0);
        issue("t7_new", 16'd5, 32'd100);
        idle("t7_n1", 1'b0, 32'h0);
        idle("t7_n2", 1'b0, 32'h0);
        idle("t7_n3", 1'b0, 32'h0);
        idle("t7_n4", 1'b0, 32'h0);
        idle("t7_nout", 1'b1, 32'd100);
        idle("t7_end", 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
